// File: rtl/spi_slave_axi_xfer.sv
// AXI-side transfer engine for the SPI slave: turns a start address plus a word
// stream into single-beat AXI4 reads/writes, auto-incrementing by one word.
module spi_slave_axi_xfer #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_ID_WIDTH   = 6
) (
  input  logic                        axi_aclk,
  input  logic                        axi_aresetn,
  input  logic [31:0]                 rx_addr,
  input  logic                        rx_addr_valid,
  input  logic                        rx_rd_wr,
  input  logic [31:0]                 rx_data,
  input  logic                        rx_data_valid,
  output logic                        rx_data_ready,
  output logic [31:0]                 tx_data,
  output logic                        tx_data_valid,
  input  logic                        tx_data_ready,
  output logic                        bus_error,
  output logic [AXI_ADDR_WIDTH-1:0]   aw_addr,
  output logic                        aw_valid,
  input  logic                        aw_ready,
  output logic [AXI_DATA_WIDTH-1:0]   w_data,
  output logic [AXI_DATA_WIDTH/8-1:0] w_strb,
  output logic                        w_last,
  output logic                        w_valid,
  input  logic                        w_ready,
  input  logic [1:0]                  b_resp,
  input  logic                        b_valid,
  output logic                        b_ready,
  output logic [AXI_ADDR_WIDTH-1:0]   ar_addr,
  output logic                        ar_valid,
  input  logic                        ar_ready,
  input  logic [AXI_DATA_WIDTH-1:0]   r_data,
  input  logic [1:0]                  r_resp,
  input  logic                        r_last,
  input  logic                        r_valid,
  output logic                        r_ready,
  output logic [AXI_ID_WIDTH-1:0]     aw_id,
  output logic [AXI_ID_WIDTH-1:0]     ar_id,
  output logic [7:0]                  aw_len,
  output logic [7:0]                  ar_len,
  output logic [2:0]                  aw_size,
  output logic [2:0]                  ar_size,
  output logic [1:0]                  aw_burst,
  output logic [1:0]                  ar_burst,
  output logic [2:0]                  aw_prot,
  output logic [2:0]                  ar_prot,
  output logic [3:0]                  aw_cache,
  output logic [3:0]                  ar_cache
);

  localparam int STRB_W = AXI_DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    IDLE, WR_WAIT, WR_REQ, WR_RESP, RD_ISSUE, RD_DATA, RD_PUSH
  } state_t;

  state_t      state;
  logic [31:0] addr_q;
  logic [31:0] wr_word;
  logic        wr_issued, aw_done, w_done;
  logic        pend_valid, pend_rd;
  logic [31:0] pend_addr;

  logic        aw_hs, w_hs, b_hs, ar_hs, r_hs, tx_hs;
  logic        accept, txn_end, goto_start, take_rd;
  logic [31:0] take_addr;
  logic [31:0] rd_lane;
  logic        unused_bits;

  assign aw_hs = aw_valid & aw_ready;
  assign w_hs  = w_valid & w_ready;
  assign b_hs  = b_valid & b_ready;
  assign ar_hs = ar_valid & ar_ready;
  assign r_hs  = r_valid & r_ready;
  assign tx_hs = tx_data_valid & tx_data_ready;

  // A start pulse in the same cycle wins over the word; the word stays in the FIFO.
  assign rx_data_ready = (state == WR_WAIT) && rx_data_valid && !rx_addr_valid;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    take_addr = rx_addr_valid ? rx_addr  : pend_addr;
    take_rd   = rx_addr_valid ? rx_rd_wr : pend_rd;
    accept    = rx_addr_valid &&
                (state == IDLE || state == WR_WAIT || (state == RD_ISSUE && !ar_valid));
    txn_end   = 1'b0;
    case (state)
      WR_RESP: txn_end = b_hs;
      RD_PUSH: txn_end = tx_hs;
      default: txn_end = 1'b0;
    endcase
    goto_start = accept || (txn_end && (rx_addr_valid || pend_valid));
  end

  assign rd_lane = (AXI_DATA_WIDTH == 64 && addr_q[2]) ? r_data[AXI_DATA_WIDTH-1 -: 32]
                                                      : r_data[31:0];

  // NOTE: asynchronous active-low reset; the FSM and every handshake output clear at once.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      state         <= IDLE;
      addr_q        <= '0;
      wr_word       <= '0;
      wr_issued     <= 1'b0;
      aw_done       <= 1'b0;
      w_done        <= 1'b0;
      pend_valid    <= 1'b0;
      pend_rd       <= 1'b0;
      pend_addr     <= '0;
      aw_valid      <= 1'b0;
      w_valid       <= 1'b0;
      b_ready       <= 1'b0;
      ar_valid      <= 1'b0;
      r_ready       <= 1'b0;
      tx_data       <= '0;
      tx_data_valid <= 1'b0;
      bus_error     <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments; later ones below override the case.
      case (state)
        IDLE: ;
        WR_WAIT: begin
          if (rx_data_ready) begin
            wr_word   <= rx_data;
            wr_issued <= 1'b0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            state     <= WR_REQ;
          end
        end
        WR_REQ: begin
          if (!wr_issued) begin
            aw_valid  <= 1'b1;
            w_valid   <= 1'b1;
            wr_issued <= 1'b1;
          end else begin
            if (aw_hs) begin
              aw_valid <= 1'b0;
              aw_done  <= 1'b1;
            end
            if (w_hs) begin
              w_valid <= 1'b0;
              w_done  <= 1'b1;
            end
            if ((aw_done || aw_hs) && (w_done || w_hs)) begin
              b_ready <= 1'b1;
              state   <= WR_RESP;
            end
          end
        end
        WR_RESP: begin
          if (b_hs) begin
            b_ready <= 1'b0;
            if (b_resp != 2'b00) bus_error <= 1'b1;
            addr_q <= addr_q + 32'd4;
            state  <= WR_WAIT;
          end
        end
        RD_ISSUE: begin
          // Only ask for data when the transmit FIFO can take it.
          if (!ar_valid) begin
            if (tx_data_ready) ar_valid <= 1'b1;
          end else if (ar_ready) begin
            ar_valid <= 1'b0;
            r_ready  <= 1'b1;
            state    <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (r_hs) begin
            r_ready       <= 1'b0;
            tx_data       <= rd_lane;
            tx_data_valid <= 1'b1;
            if (r_resp != 2'b00) bus_error <= 1'b1;
            state         <= RD_PUSH;
          end
        end
        RD_PUSH: begin
          if (tx_hs) begin
            tx_data_valid <= 1'b0;
            addr_q        <= addr_q + 32'd4;
            state         <= RD_ISSUE;
          end
        end
        default: state <= IDLE;
      endcase

      if (rx_addr_valid && !goto_start) begin
        pend_valid <= 1'b1;
        pend_addr  <= rx_addr;
        pend_rd    <= rx_rd_wr;
      end

      if (goto_start) begin
        addr_q     <= {take_addr[31:2], 2'b00};
        pend_valid <= 1'b0;
        state      <= take_rd ? RD_ISSUE : WR_WAIT;
        ar_valid   <= take_rd && tx_data_ready;
      end

      if (rx_addr_valid) bus_error <= 1'b0;
    end
  end

  assign aw_addr  = AXI_ADDR_WIDTH'(addr_q);
  assign ar_addr  = AXI_ADDR_WIDTH'(addr_q);
  assign w_data   = {(AXI_DATA_WIDTH/32){wr_word}};
  assign w_strb   = (AXI_DATA_WIDTH == 64) ? STRB_W'(addr_q[2] ? 8'hF0 : 8'h0F)
                                           : STRB_W'(4'hF);
  assign w_last   = 1'b1;
  assign aw_id    = '0;
  assign ar_id    = '0;
  assign aw_len   = 8'd0;
  assign ar_len   = 8'd0;
  assign aw_size  = 3'b010;
  assign ar_size  = 3'b010;
  assign aw_burst = 2'b01;
  assign ar_burst = 2'b01;
  assign aw_prot  = 3'b000;
  assign ar_prot  = 3'b000;
  assign aw_cache = 4'b0000;
  assign ar_cache = 4'b0000;

  assign unused_bits = ^{r_last, take_addr[1:0]};

endmodule

// File: tb/tb_spi_slave_axi_xfer.sv
// Scoreboard bench for spi_slave_axi_xfer: directed transfers against a small
// AXI slave model; a monitor pops expected AW/W/AR/TX beats on every handshake.
module tb_spi_slave_axi_xfer;

  logic        clk, axi_aresetn;
  logic [31:0] rx_addr, rx_data, tx_data;
  logic        rx_addr_valid, rx_rd_wr, rx_data_valid, rx_data_ready;
  logic        tx_data_valid, tx_data_ready, bus_error;
  logic [31:0] aw_addr, ar_addr;
  logic        aw_valid, aw_ready, w_last, w_valid, w_ready, b_valid, b_ready;
  logic        ar_valid, ar_ready, r_last, r_valid, r_ready;
  logic [63:0] w_data, r_data;
  logic [7:0]  w_strb, aw_len, ar_len;
  logic [1:0]  b_resp, r_resp, aw_burst, ar_burst;
  logic [5:0]  aw_id, ar_id;
  logic [2:0]  aw_size, ar_size, aw_prot, ar_prot;
  logic [3:0]  aw_cache, ar_cache;

  spi_slave_axi_xfer dut (
    .axi_aclk(clk), .axi_aresetn(axi_aresetn),
    .rx_addr(rx_addr), .rx_addr_valid(rx_addr_valid), .rx_rd_wr(rx_rd_wr),
    .rx_data(rx_data), .rx_data_valid(rx_data_valid), .rx_data_ready(rx_data_ready),
    .tx_data(tx_data), .tx_data_valid(tx_data_valid), .tx_data_ready(tx_data_ready),
    .bus_error(bus_error),
    .aw_addr(aw_addr), .aw_valid(aw_valid), .aw_ready(aw_ready),
    .w_data(w_data), .w_strb(w_strb), .w_last(w_last), .w_valid(w_valid), .w_ready(w_ready),
    .b_resp(b_resp), .b_valid(b_valid), .b_ready(b_ready),
    .ar_addr(ar_addr), .ar_valid(ar_valid), .ar_ready(ar_ready),
    .r_data(r_data), .r_resp(r_resp), .r_last(r_last), .r_valid(r_valid), .r_ready(r_ready),
    .aw_id(aw_id), .ar_id(ar_id), .aw_len(aw_len), .ar_len(ar_len),
    .aw_size(aw_size), .ar_size(ar_size), .aw_burst(aw_burst), .ar_burst(ar_burst),
    .aw_prot(aw_prot), .ar_prot(ar_prot), .aw_cache(aw_cache), .ar_cache(ar_cache)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  strb;
  } w_exp_t;

  logic [31:0] exp_aw[$];
  w_exp_t      exp_w[$];
  logic [31:0] exp_ar[$];
  logic [31:0] exp_tx[$];

  int pass_cnt = 0;
  int total_cnt = 0;
  int tx_seen = 0, ar_seen = 0, b_seen = 0;

  // Slave behaviour knobs, written only by the stimulus process.
  logic        aw_delay = 1'b0;
  logic        wr_stall = 1'b0;
  logic [31:0] rerr_addr = 32'hFFFF_FFFF;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic failure(input string name);
    total_cnt++;
    $display("FAIL %s: event did not occur within its cycle budget", name);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_1000: mem_word = 32'h1122_3344;
      32'h0000_1004: mem_word = 32'h5566_7788;
      32'h0000_3000: mem_word = 32'hCAFE_F00D;
      default:       mem_word = 32'hA5A5_0000 ^ a;
    endcase
  endfunction

  // AXI slave model: samples handshakes mid-cycle, drives responses just after the edge.
  initial begin : axi_slave
    logic        f_aw, f_w, f_b, f_ar, f_r, got_aw, got_w;
    logic [31:0] a_cap, a8;
    int          w_age;
    aw_ready = 0; w_ready = 0; b_valid = 0; b_resp = 0;
    ar_ready = 0; r_valid = 0; r_data = 0; r_resp = 0; r_last = 0;
    got_aw = 0; got_w = 0; w_age = 0;
    forever begin
      @(negedge clk);
      f_aw = aw_valid && aw_ready;
      f_w  = w_valid && w_ready;
      f_b  = b_valid && b_ready;
      f_ar = ar_valid && ar_ready;
      f_r  = r_valid && r_ready;
      a_cap = ar_addr;
      @(posedge clk); #1;
      if (f_w) begin got_w = 1; w_age = 0; end
      else if (got_w) w_age++;
      if (f_aw) got_aw = 1;
      if (f_b) b_valid = 0;
      if (got_aw && got_w && !b_valid) begin
        b_valid = 1; b_resp = 2'b00; got_aw = 0; got_w = 0;
      end
      w_ready  = !wr_stall;
      aw_ready = !wr_stall && (!aw_delay || (got_w && w_age >= 3));
      ar_ready = 1;
      if (f_r) r_valid = 0;
      if (f_ar) begin
        a8      = a_cap & 32'hFFFF_FFF8;
        r_valid = 1;
        r_data  = {mem_word(a8 + 32'd4), mem_word(a8)};
        r_resp  = (a_cap == rerr_addr) ? 2'b10 : 2'b00;
        r_last  = 1;
      end
    end
  end

  // Monitor: compares every DUT-presented beat against the scoreboard queues.
  initial begin : monitor
    logic   wr_out, prev_ar_valid, prev_tx_ready;
    w_exp_t we;
    wr_out = 0; prev_ar_valid = 0; prev_tx_ready = 0;
    forever begin
      @(negedge clk);
      if (!axi_aresetn) continue;
      if (ar_valid && !prev_ar_valid) check("ar_raised_with_tx_ready", prev_tx_ready, 1'b1);
      if (aw_valid && aw_ready) begin
        check("aw_while_b_outstanding", wr_out, 1'b0);
        if (exp_aw.size() == 0) begin
          total_cnt++;
          $display("FAIL unexpected_aw: got addr 0x%0h, expected none", aw_addr);
        end else check("aw_addr", aw_addr, exp_aw.pop_front());
        wr_out = 1;
      end
      if (w_valid && w_ready) begin
        if (exp_w.size() == 0) begin
          total_cnt++;
          $display("FAIL unexpected_w: got data 0x%0h, expected none", w_data);
        end else begin
          we = exp_w.pop_front();
          check("w_data", w_data, we.data);
          check("w_strb", w_strb, we.strb);
          check("w_last", w_last, 1'b1);
        end
      end
      if (b_valid && b_ready) begin wr_out = 0; b_seen++; end
      if (ar_valid && ar_ready) begin
        if (exp_ar.size() == 0) begin
          total_cnt++;
          $display("FAIL unexpected_ar: got addr 0x%0h, expected none", ar_addr);
        end else check("ar_addr", ar_addr, exp_ar.pop_front());
        ar_seen++;
      end
      if (tx_data_valid && tx_data_ready) begin
        if (exp_tx.size() == 0) begin
          total_cnt++;
          $display("FAIL unexpected_tx: got 0x%0h, expected none", tx_data);
        end else check("tx_data", tx_data, exp_tx.pop_front());
        tx_seen++;
      end
      prev_ar_valid = ar_valid;
      prev_tx_ready = tx_data_ready;
    end
  end

  // All stimulus tasks start and end just after a rising edge.
  task automatic start(input logic [31:0] a, input logic rd);
    rx_addr = a; rx_rd_wr = rd; rx_addr_valid = 1;
    @(posedge clk); #1;
    rx_addr_valid = 0;
  endtask

  task automatic push_word(input logic [31:0] w, input logic [31:0] a, input logic [7:0] strb);
    logic got;
    exp_aw.push_back(a);
    exp_w.push_back('{data: {w, w}, strb: strb});
    rx_data = w; rx_data_valid = 1; got = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (rx_data_ready) begin got = 1; break; end
    end
    if (!got) failure("rx_pop");
    @(posedge clk); #1;
    rx_data_valid = 0;
  endtask

  task automatic wait_for(input string name, input int kind, input int target);
    logic ok;
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if ((kind == 0 && tx_seen >= target) || (kind == 1 && ar_seen >= target) ||
          (kind == 2 && b_seen >= target)) begin ok = 1; break; end
    end
    if (!ok) failure(name);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $fatal(1);
  end

  initial begin : stimulus
    logic seen;
    axi_aresetn = 0; rx_addr = 0; rx_addr_valid = 0; rx_rd_wr = 0;
    rx_data = 0; rx_data_valid = 1; tx_data_ready = 1;
    #3;
    check("rst_aw_valid", aw_valid, 0);
    check("rst_w_valid", w_valid, 0);
    check("rst_b_ready", b_ready, 0);
    check("rst_ar_valid", ar_valid, 0);
    check("rst_r_ready", r_ready, 0);
    check("rst_rx_data_ready", rx_data_ready, 0);
    check("rst_tx_data_valid", tx_data_valid, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_bus_error", bus_error, 0);
    check("rst_aw_addr", aw_addr, 0);
    check("const_aw_size", aw_size, 3'b010);
    check("const_ar_burst", ar_burst, 2'b01);
    check("const_ids_len", {aw_id, ar_id, aw_len, ar_len}, 0);
    rx_data_valid = 0;
    repeat (2) @(posedge clk);
    #1 axi_aresetn = 1;
    @(posedge clk); #1;

    // Single write in the upper lane; checks two-cycle issue latency.
    start(32'h1A10_0004, 0);
    push_word(32'hDEAD_BEEF, 32'h1A10_0004, 8'hF0);
    @(negedge clk); check("wr_lat_cycle1_aw_low", aw_valid, 0);
    @(negedge clk); check("wr_lat_cycle2_aw_w_high", {aw_valid, w_valid}, 2'b11);
    wait_for("wr1_b", 2, 1);
    check("wr1_bus_error", bus_error, 0);

    // Three-word burst with AW held off behind W.
    aw_delay = 1;
    start(32'h0000_0000, 0);
    push_word(32'h0101_0101, 32'h0000_0000, 8'h0F);
    push_word(32'h0202_0202, 32'h0000_0004, 8'hF0);
    push_word(32'h0303_0303, 32'h0000_0008, 8'h0F);
    wait_for("wr_burst_b", 2, 4);
    aw_delay = 0;

    // Read burst that stalls when the transmit FIFO fills.
    exp_ar.push_back(32'h0000_1000); exp_ar.push_back(32'h0000_1004);
    exp_tx.push_back(32'h1122_3344); exp_tx.push_back(32'h5566_7788);
    start(32'h0000_1000, 1);
    @(negedge clk); check("rd_lat_ar_valid", ar_valid, 1);
    wait_for("rd_two_words", 0, 2);
    tx_data_ready = 0;
    repeat (10) @(posedge clk);
    #1;

    // SLVERR read: word still delivered, error sticky until the next start.
    rerr_addr = 32'h0000_3000;
    exp_ar.push_back(32'h0000_3000); exp_tx.push_back(32'hCAFE_F00D);
    start(32'h0000_3000, 1);
    tx_data_ready = 1;
    wait_for("rd_err_word", 0, 3);
    tx_data_ready = 0;
    repeat (3) @(negedge clk);
    check("rd_slverr_sticky", bus_error, 1);
    @(posedge clk); #1;

    // Write start arriving mid-read is deferred until the read completes.
    exp_ar.push_back(32'h0000_1000); exp_tx.push_back(32'h1122_3344);
    start(32'h0000_1000, 1);
    @(negedge clk); check("bus_error_cleared_by_start", bus_error, 0);
    @(posedge clk); #1;
    tx_data_ready = 1;
    wait_for("rd_pend_ar", 1, 4);
    check("in_rd_data_r_ready", r_ready, 1);
    start(32'h0000_2000, 0);
    push_word(32'h0BAD_F00D, 32'h0000_2000, 8'h0F);
    wait_for("pend_write_b", 2, 5);
    repeat (6) @(posedge clk);
    #1;
    check("exp_aw_drained", exp_aw.size(), 0);
    check("exp_w_drained", exp_w.size(), 0);
    check("exp_ar_drained", exp_ar.size(), 0);
    check("exp_tx_drained", exp_tx.size(), 0);

    // Asynchronous reset while AW is stalled.
    wr_stall = 1;
    start(32'h0000_4000, 0);
    rx_data = 32'h4444_4444; rx_data_valid = 1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (aw_valid) begin seen = 1; break; end
    end
    if (!seen) failure("stall_aw_valid");
    #2 axi_aresetn = 0;
    #1;
    check("async_rst_aw_valid", aw_valid, 0);
    check("async_rst_w_valid", w_valid, 0);
    check("async_rst_rx_data_ready", rx_data_ready, 0);
    check("async_rst_tx_data_valid", tx_data_valid, 0);
    check("async_rst_bus_error", bus_error, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
